balance_scan_driver: RTL and testbench
======================================

Name: balance_scan_driver

Overview:
Drives the 8-digit seven-segment display for the SHOW_BALANCES screen; its AN/led outputs feed the display output multiplexer.
- BTNU cycles through the five account balances.
- Leftmost digit shows a currency letter; the lower seven digits show the selected balance in decimal.
- Binary-to-BCD uses a sequential double-dabble engine; all digits are time-multiplexed with a refresh counter.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles btn_next must be stable before accepted (10 ms at 100 MHz)
REFRESH_CYCLES, 100000, cycles each digit is lit per scan slot (1 ms at 100 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_next  input  1  raw BTNU, asynchronous to clk
balance_dollars  input  32  unsigned dollar balance
balance_btc  input  32  unsigned BTC balance
balance_eth  input  32  unsigned ETH balance
balance_xrp  input  32  unsigned XRP balance
balance_ltc  input  32  unsigned LTC balance
AN  output  8  digit anodes, active-low, one-hot; AN[0] = rightmost
led  output  7  segments {g,f,e,d,c,b,a}, active-low
sel  output  3  selected currency: 0 dollars, 1 btc, 2 eth, 3 xrp, 4 ltc
busy  output  1  high while a BCD conversion is in flight

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - sel=0, AN=8'hFF, led=7'h7F, busy=0.
  - Scan index=0; refresh and debounce counters=0.
  - Digit registers: all blank; force_conv=1.
- Button path:
  - btn_next passes a 2-FF synchronizer, then the debounce counter.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Each debounced rising edge advances sel 0->1->2->3->4->0; holding the button gives exactly one advance.
- Conversion FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE -> LOAD when force_conv=1, sel changed, or the selected balance != shown_value.
  - LOAD (1 cycle): snapshot the selected balance into shown_value and work_reg; clear the 28-bit BCD accumulator; clear force_conv.
  - SHIFT (24 cycles): each cycle add 3 to every BCD nibble >=5, then shift {bcd, work_reg[23:0]} left by 1.
  - COMMIT (1 cycle): update the 7 numeric digit registers and the overflow flag atomically; return to IDLE.
  - busy=1 in LOAD, SHIFT and COMMIT. The new digits are visible from the cycle after COMMIT, i.e. the 27th cycle after IDLE detects the trigger.
  - A sel change or input change during a conversion does not abort it; the mismatch check in IDLE starts a new conversion.
- Overflow: if snapshot > 9_999_999, the conversion result is discarded and COMMIT sets overflow. Digits 6..0 then show '-' (7'b0111111).
- Leading-zero blanking: numeric digits above the most significant nonzero digit are blank (7'h7F). Digit 0 always shows (value 0 shows "0").
- Currency letter on digit 7:
  - d = 7'b0100001
  - b = 7'b0000011
  - E = 7'b0000110
  - r = 7'b0101111
  - L = 7'b1000111
  - The letter follows sel immediately, independent of busy.
- Numeric segment encodings: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
- Scan:
  - The refresh counter counts 0..REFRESH_CYCLES-1; on wrap the scan index increments 0..7 and wraps to 0.
  - AN = ~(1<<index); led is registered and aligned with AN in the same cycle.
  - The first scan output appears at index 0 once the counter first wraps after reset.
- Reset mid-operation: an asynchronous reset during SHIFT returns everything to reset values. A fresh conversion starts after release because force_conv=1.

Test Plan:
- Reset release with balance_dollars=1234567: busy rises, falls after 26 cycles; digits 6..0 show "1234567"; digit 7 shows 'd'; AN walks FE,FD,...,7F.
- balance_dollars=0: only digit 0 shows 7'b1000000; digits 6..1 blank (7'h7F).
- balance_btc=10_000_000, press btn_next once (held > DEBOUNCE_CYCLES): sel=1; digit 7 shows 'b'; digits 6..0 show '-'.
- Button chatter shorter than DEBOUNCE_CYCLES: sel unchanged. Five valid presses from sel=0: sel returns to 0.
- Change balance_dollars 42 -> 9999999 mid-SHIFT: first commit shows "42"; a second conversion follows, ending with "9999999".
- Assert rst_n low during SHIFT: AN=FF, led=7F, sel=0 immediately; after release, correct digits reappear within 27 cycles.

Source files
------------

// File: rtl/balance_scan_driver_if.sv
// Balance inputs and display outputs of the SHOW_BALANCES scan driver.
// master: the driver itself; slave: the balance source / display mux side.
interface balance_scan_driver_if;
    logic [31:0] balance_dollars;
    logic [31:0] balance_btc;
    logic [31:0] balance_eth;
    logic [31:0] balance_xrp;
    logic [31:0] balance_ltc;
    logic [7:0]  AN;
    logic [6:0]  led;
    logic [2:0]  sel;
    logic        busy;

    modport master (
        input  balance_dollars, balance_btc, balance_eth, balance_xrp, balance_ltc,
        output AN, led, sel, busy
    );

    modport slave (
        output balance_dollars, balance_btc, balance_eth, balance_xrp, balance_ltc,
        input  AN, led, sel, busy
    );
endinterface

// File: rtl/balance_scan_driver.sv
// SHOW_BALANCES seven-segment driver: debounced currency select, sequential
// double-dabble binary-to-BCD conversion and time-multiplexed 8-digit scan.
module balance_scan_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REFRESH_CYCLES  = 100000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btn_next,
    balance_scan_driver_if.master        bus
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RfW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [31:0] MaxShown = 32'd9_999_999;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

    // Button path
    logic [1:0]     r_sync;
    logic           r_db_level;
    logic [DbW-1:0] r_db_cnt;
    logic [2:0]     r_sel;
    logic           w_sync;

    // Conversion engine
    state_e         r_state;
    state_e         w_state_nxt;
    logic           w_load;
    logic           w_shift;
    logic           w_commit;
    logic           r_force;
    logic [31:0]    r_shown;
    logic [2:0]     r_conv_sel;
    logic [23:0]    r_work;
    logic [27:0]    r_bcd;
    logic [27:0]    w_bcd_adj;
    logic [4:0]     r_shift_cnt;
    logic           r_ovf_pend;
    logic [31:0]    w_sel_bal;

    // Displayed result
    logic [6:0][3:0] r_digit;
    logic            r_valid;
    logic            r_overflow;
    logic [7:0][3:0] w_dig_ext;
    logic [7:0]      w_nz;

    // Scan
    logic [RfW-1:0] r_ref_cnt;
    logic [2:0]     r_index;
    logic [7:0]     r_an;
    logic [6:0]     r_led;
    logic [6:0]     w_seg_cur;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_sync = r_sync[1];

    // Synchronise, debounce and advance sel on each debounced rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b00;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_sel      <= 3'd0;
        end else begin
            r_sync <= {r_sync[0], btn_next};
            if (w_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbW'(DEBOUNCE_CYCLES - 1)) begin
                r_db_level <= w_sync;
                r_db_cnt   <= '0;
                if (w_sync) begin
                    r_sel <= (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;
                end
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Balance currently selected for display
    always_comb begin
        w_sel_bal = bus.balance_dollars;
        case (r_sel)
            3'd1:    w_sel_bal = bus.balance_btc;
            3'd2:    w_sel_bal = bus.balance_eth;
            3'd3:    w_sel_bal = bus.balance_xrp;
            3'd4:    w_sel_bal = bus.balance_ltc;
            default: w_sel_bal = bus.balance_dollars;
        endcase
    end

    // Conversion FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion FSM next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_force || (r_sel != r_conv_sel) || (w_sel_bal != r_shown)) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                w_load      = 1'b1;
                w_state_nxt = StShift;
            end
            StShift: begin
                w_shift = 1'b1;
                if (r_shift_cnt == 5'd23) begin
                    w_state_nxt = StCommit;
                end
            end
            StCommit: begin
                w_commit    = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 7; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Double-dabble datapath and atomic commit of the displayed digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_force     <= 1'b1;
            r_shown     <= '0;
            r_conv_sel  <= 3'd0;
            r_work      <= '0;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_ovf_pend  <= 1'b0;
            r_digit     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shown     <= w_sel_bal;
                r_conv_sel  <= r_sel;
                r_work      <= w_sel_bal[23:0];
                r_bcd       <= '0;
                r_force     <= 1'b0;
                r_shift_cnt <= '0;
                r_ovf_pend  <= (w_sel_bal > MaxShown);
            end
            if (w_shift) begin
                r_bcd       <= {w_bcd_adj[26:0], r_work[23]};
                r_work      <= {r_work[22:0], 1'b0};
                r_shift_cnt <= r_shift_cnt + 5'd1;
            end
            if (w_commit) begin
                r_valid    <= 1'b1;
                r_overflow <= r_ovf_pend;
                // An out-of-range result is dropped; dashes are shown instead
                if (!r_ovf_pend) begin
                    r_digit <= r_bcd;
                end
            end
        end
    end

    // w_nz[i]: some digit at position i or above is nonzero (leading-zero blanking)
    assign w_dig_ext = {4'd0, r_digit};

    always_comb begin : p_nz
        logic v_acc;
        v_acc = 1'b0;
        w_nz  = '0;
        for (int i = 7; i >= 0; i--) begin
            v_acc   = v_acc | (w_dig_ext[i] != 4'd0);
            w_nz[i] = v_acc;
        end
    end

    // Segment pattern for the digit at the current scan index
    always_comb begin
        w_seg_cur = 7'h7F;
        if (r_index == 3'd7) begin
            case (r_sel)
                3'd0:    w_seg_cur = 7'b0100001;
                3'd1:    w_seg_cur = 7'b0000011;
                3'd2:    w_seg_cur = 7'b0000110;
                3'd3:    w_seg_cur = 7'b0101111;
                3'd4:    w_seg_cur = 7'b1000111;
                default: w_seg_cur = 7'h7F;
            endcase
        end else if (!r_valid) begin
            w_seg_cur = 7'h7F;
        end else if (r_overflow) begin
            w_seg_cur = 7'b0111111;
        end else if ((r_index == 3'd0) || w_nz[r_index]) begin
            w_seg_cur = seg_digit(w_dig_ext[r_index]);
        end
    end

    // Refresh counter; AN and led are loaded together on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_index   <= 3'd0;
            r_an      <= 8'hFF;
            r_led     <= 7'h7F;
        end else if (r_ref_cnt == RfW'(REFRESH_CYCLES - 1)) begin
            r_ref_cnt <= '0;
            r_index   <= r_index + 3'd1;
            r_an      <= ~(8'd1 << r_index);
            r_led     <= w_seg_cur;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign bus.AN   = r_an;
    assign bus.led  = r_led;
    assign bus.sel  = r_sel;
    assign bus.busy = (r_state != StIdle);

endmodule

// File: tb/tb_balance_scan_driver.sv
// Directed bench for balance_scan_driver with shortened debounce/refresh times.
module tb_balance_scan_driver;

    localparam int unsigned DB = 8;
    localparam int unsigned RF = 2;

    logic clk;
    logic rst_n;
    logic btn_next;
    int   n_cmp;
    int   n_bad;

    balance_scan_driver_if bus_if();

    balance_scan_driver #(
        .DEBOUNCE_CYCLES (DB),
        .REFRESH_CYCLES  (RF)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] val;
        string       exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no event, required one", name);
    endtask

    function automatic logic [6:0] ch2seg(input byte c);
        case (c)
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            "-": return 7'b0111111;
            "d": return 7'b0100001;
            "b": return 7'b0000011;
            "E": return 7'b0000110;
            "r": return 7'b0101111;
            "L": return 7'b1000111;
            default: return 7'h7F;
        endcase
    endfunction

    // Leftmost character of s is digit 7
    function automatic logic [55:0] pat(input string s);
        logic [55:0] p;
        p = '1;
        for (int i = 0; i < 8; i++) p[(7-i)*7 +: 7] = ch2seg(s[i]);
        return p;
    endfunction

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int t;
        t = 0;
        while (bus_if.busy !== lvl && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (bus_if.busy !== lvl) timeout(name);
    endtask

    task automatic wait_conv(input string name, output int busy_len);
        busy_len = 0;
        wait_busy(1'b1, 8, {name, " busy_rise"});
        while (bus_if.busy === 1'b1 && busy_len < 60) begin
            @(negedge clk);
            busy_len++;
        end
        if (bus_if.busy !== 1'b0) timeout({name, " busy_fall"});
    endtask

    // Collect one full scan of all eight digits, starting after any slot in flight
    task automatic check_scan(input string name, input string exp);
        logic [55:0] got;
        logic [7:0]  seen;
        logic [7:0]  m;
        got  = '1;
        seen = '0;
        repeat (RF + 1) @(negedge clk);
        for (int c = 0; c < 8 * RF; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                m = 8'd1 << k;
                if (bus_if.AN === ~m) begin
                    got[k*7 +: 7] = bus_if.led;
                    seen[k]       = 1'b1;
                end
            end
        end
        check({name, " seen"}, 64'(seen), 64'hFF);
        check({name, " digits"}, 64'(got), 64'(pat(exp)));
    endtask

    task automatic press();
        btn_next = 1'b1;
        repeat (DB + 12) @(negedge clk);
        btn_next = 1'b0;
        repeat (DB + 12) @(negedge clk);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [7:0]  walk[8];
        logic [2:0]  cur_sel[5];
        string       cur_exp[5];
        logic [7:0]  prev_an;
        int          blen;
        int          t;

        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{32'd0,          "d      0"};
        tbl[1] = '{32'd42,         "d     42"};
        tbl[2] = '{32'd9_999_999,  "d9999999"};
        tbl[3] = '{32'd10_000_000, "d-------"};
        tbl[4] = '{32'd1_000_000,  "d1000000"};
        tbl[5] = '{32'd7,          "d      7"};
        tbl[6] = '{32'hFFFF_FFFF,  "d-------"};

        walk = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        cur_sel = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        cur_exp = '{"b-------", "E      5", "r9999999", "L   1000", "d9999999"};

        rst_n    = 1'b0;
        btn_next = 1'b0;
        bus_if.balance_dollars = 32'd1_234_567;
        bus_if.balance_btc     = 32'd10_000_000;
        bus_if.balance_eth     = 32'd5;
        bus_if.balance_xrp     = 32'd9_999_999;
        bus_if.balance_ltc     = 32'd1000;

        repeat (3) @(negedge clk);
        check("reset AN", 64'(bus_if.AN), 64'hFF);
        check("reset led", 64'(bus_if.led), 64'h7F);
        check("reset sel", 64'(bus_if.sel), 64'd0);
        check("reset busy", 64'(bus_if.busy), 64'd0);

        rst_n = 1'b1;
        wait_conv("initial", blen);
        check("initial busy length", 64'(blen), 64'd26);
        check_scan("initial 1234567", "d1234567");

        // Anode walk FE..7F
        t = 0;
        while (bus_if.AN !== 8'hFE && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (bus_if.AN !== 8'hFE) timeout("AN walk start");
        for (int j = 1; j < 8; j++) begin
            prev_an = bus_if.AN;
            t = 0;
            while (bus_if.AN === prev_an && t < 10) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("AN walk step %0d", j), 64'(bus_if.AN), 64'(walk[j]));
        end

        // Table of dollar balances
        for (int i = 0; i < 7; i++) begin
            bus_if.balance_dollars = tbl[i].val;
            wait_conv($sformatf("vec %0d", i), blen);
            check($sformatf("vec %0d busy length", i), 64'(blen), 64'd26);
            check_scan($sformatf("vec %0d", i), tbl[i].exp);
        end

        // Input change mid-SHIFT: 42 commits first, then 9999999
        bus_if.balance_dollars = 32'd42;
        wait_busy(1'b1, 8, "midshift rise");
        repeat (5) @(negedge clk);
        bus_if.balance_dollars = 32'd9_999_999;
        wait_busy(1'b0, 40, "midshift first fall");
        check_scan("midshift first", "d     42");
        wait_busy(1'b1, 40, "midshift second rise");
        wait_busy(1'b0, 40, "midshift second fall");
        check_scan("midshift second", "d9999999");

        // Chatter shorter than the debounce window
        for (int i = 0; i < 4; i++) begin
            btn_next = 1'b1;
            repeat (3) @(negedge clk);
            btn_next = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (DB + 10) @(negedge clk);
        check("chatter sel", 64'(bus_if.sel), 64'd0);

        // Five presses walk every currency and return to dollars
        for (int i = 0; i < 5; i++) begin
            press();
            check($sformatf("press %0d sel", i), 64'(bus_if.sel), 64'(cur_sel[i]));
            check($sformatf("press %0d busy", i), 64'(bus_if.busy), 64'd0);
            check_scan($sformatf("press %0d", i), cur_exp[i]);
        end

        // Asynchronous reset during SHIFT
        press();
        check("prereset sel", 64'(bus_if.sel), 64'd1);
        bus_if.balance_btc = 32'd123;
        wait_busy(1'b1, 8, "prereset rise");
        repeat (4) @(negedge clk);
        check("prereset AN scanning", 64'(bus_if.AN != 8'hFF), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset AN", 64'(bus_if.AN), 64'hFF);
        check("midreset led", 64'(bus_if.led), 64'h7F);
        check("midreset sel", 64'(bus_if.sel), 64'd0);
        check("midreset busy", 64'(bus_if.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_conv("postreset", blen);
        check("postreset busy length", 64'(blen), 64'd26);
        check_scan("postreset", "d9999999");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
